siso_shift_ctrl: RTL and testbench

Sequencing controller for the serial-in/serial-out shift register datapath. Accepts a shift request (length, direction) over a valid/ready handshake, then drives the register's load and shift-enable strobes for exactly the requested number of cycles. It reports completion or abort with single-cycle pulses. Sits between the command source and one shift register instance.

---
 rtl/siso_shift_ctrl.sv | 106 ++++++++++
 tb/tb_siso_shift_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_ctrl.sv
// Sequencing controller for a serial-in/serial-out shift register.
// Accepts a length/direction request, then drives load and shift strobes.
module siso_shift_ctrl #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_len,
  input  logic             req_dir,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic             sr_dir,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] len_nx;
  logic             accept;
  logic             last;
  logic             abort_hit;

  // Zero or oversize lengths mean a full-width shift.
  always_comb begin
    len_nx = req_len;
    if (req_len == '0 || req_len > LEN_MAX)
      len_nx = LEN_MAX;
  end

  assign accept    = req_valid & req_ready;
  assign last      = (bit_cnt == len_eff - ONE);
  assign abort_hit = abort & busy;

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    sr_load     = 1'b0;
    sr_shift_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = LOAD;
      end
      LOAD: begin
        sr_load  = 1'b1;
        busy     = 1'b1;
        state_nx = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        sr_shift_en = 1'b1;
        busy        = 1'b1;
        if (abort)
          state_nx = IDLE;
        else if (last)
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      len_eff <= '0;
      sr_dir  <= 1'b0;
      bit_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nx;
      aborted <= abort_hit;
      if (accept) begin
        len_eff <= len_nx;
        sr_dir  <= req_dir;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl.
// Inputs change on falling edges; outputs are sampled there too.
module tb_siso_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_len;
  logic       req_dir;
  logic       abort;
  logic       sr_load;
  logic       sr_shift_en;
  logic       sr_dir;
  logic       busy;
  logic [2:0] bit_cnt;
  logic       done;
  logic       aborted;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(6), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_len(req_len),
    .req_dir(req_dir),
    .abort(abort),
    .sr_load(sr_load),
    .sr_shift_en(sr_shift_en),
    .sr_dir(sr_dir),
    .busy(busy),
    .bit_cnt(bit_cnt),
    .done(done),
    .aborted(aborted)
  );

  // {req_ready,sr_load,sr_shift_en,sr_dir,busy,bit_cnt,done,aborted}
  function automatic logic [9:0] outs();
    return {req_ready, sr_load, sr_shift_en, sr_dir, busy,
            bit_cnt, done, aborted};
  endfunction

  localparam logic [9:0] RST_OUT = 10'b1_0_0_0_0_000_0_0;

  // Issues one request at the next edge, then records events per cycle.
  // Cycle 1 is the cycle right after the acceptance edge.
  task automatic run_op(
    input  logic [2:0] len,
    input  logic       dir,
    input  int         abort_at,
    input  int         ncyc,
    output int         n_load,
    output int         n_shift,
    output int         n_done,
    output int         n_abort,
    output int         load_at,
    output int         shift_first,
    output int         shift_last,
    output int         done_at,
    output int         abort_pulse_at,
    output int         ready_at,
    output logic [2:0] cnt_end
  );
    n_load = 0; n_shift = 0; n_done = 0; n_abort = 0;
    load_at = -1; shift_first = -1; shift_last = -1;
    done_at = -1; abort_pulse_at = -1; ready_at = -1;
    req_valid = 1'b1;
    req_len   = len;
    req_dir   = dir;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (sr_load) begin
        n_load++;
        if (load_at < 0) load_at = c;
      end
      if (sr_shift_en) begin
        n_shift++;
        if (shift_first < 0) shift_first = c;
        shift_last = c;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (aborted) begin
        n_abort++;
        if (abort_pulse_at < 0) abort_pulse_at = c;
      end
      if (req_ready && ready_at < 0) ready_at = c;
      abort = (c == abort_at);
    end
    abort   = 1'b0;
    cnt_end = bit_cnt;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_len = '0;
    req_dir = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs() !== RST_OUT) begin
      fails++;
      $display("FAIL reset_outs got=%b exp=%b", outs(), RST_OUT);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (outs() !== RST_OUT) begin
      fails++;
      $display("FAIL idle_outs got=%b exp=%b", outs(), RST_OUT);
    end
  endtask

  task automatic test_len6();
    int nl, ns, nd, na, la, sf, sl, da, ap, ra;
    logic [2:0] ce;
    run_op(3'd6, 1'b0, -1, 12, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (nl !== 1 || la !== 1) begin
      fails++;
      $display("FAIL len6_load got n=%0d at=%0d exp n=1 at=1", nl, la);
    end
    tests++;
    if (ns !== 6 || sf !== 2 || sl !== 7) begin
      fails++;
      $display("FAIL len6_shift got n=%0d %0d..%0d exp n=6 2..7",
               ns, sf, sl);
    end
    tests++;
    if (nd !== 1 || da !== 8 || na !== 0) begin
      fails++;
      $display("FAIL len6_done got n=%0d at=%0d ab=%0d exp 1 8 0",
               nd, da, na);
    end
    tests++;
    if (ra !== 9) begin
      fails++;
      $display("FAIL len6_ready got=%0d exp=9", ra);
    end
    tests++;
    if (ce !== 3'd6) begin
      fails++;
      $display("FAIL len6_cnt got=%0d exp=6", ce);
    end
  endtask

  task automatic test_len_clamp();
    int nl, ns, nd, na, la, sf, sl, da, ap, ra;
    logic [2:0] ce;
    run_op(3'd0, 1'b1, -1, 12, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 6 || ce !== 3'd6 || da !== 8) begin
      fails++;
      $display("FAIL len0 got shifts=%0d cnt=%0d done=%0d exp 6 6 8",
               ns, ce, da);
    end
    tests++;
    if (sr_dir !== 1'b1) begin
      fails++;
      $display("FAIL len0_dir got=%b exp=1", sr_dir);
    end
    run_op(3'd7, 1'b0, -1, 12, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 6 || ce !== 3'd6 || da !== 8) begin
      fails++;
      $display("FAIL len7 got shifts=%0d cnt=%0d done=%0d exp 6 6 8",
               ns, ce, da);
    end
    run_op(3'd1, 1'b0, -1, 6, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 1 || sf !== 2 || la !== 1 || da !== 3 || ce !== 3'd1) begin
      fails++;
      $display("FAIL len1 got sh=%0d@%0d ld=%0d dn=%0d cnt=%0d exp 1@2 1 3 1",
               ns, sf, la, da, ce);
    end
  endtask

  task automatic test_abort();
    int nl, ns, nd, na, la, sf, sl, da, ap, ra;
    logic [2:0] ce;
    run_op(3'd4, 1'b0, 3, 10, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 2 || sl !== 3) begin
      fails++;
      $display("FAIL abort_mid_shift got n=%0d last=%0d exp 2 3", ns, sl);
    end
    tests++;
    if (na !== 1 || ap !== 4 || nd !== 0) begin
      fails++;
      $display("FAIL abort_mid_pulse got ab=%0d@%0d dn=%0d exp 1@4 0",
               na, ap, nd);
    end
    tests++;
    if (ra !== 4 || ce !== 3'd2) begin
      fails++;
      $display("FAIL abort_mid_state got ready=%0d cnt=%0d exp 4 2", ra, ce);
    end
    run_op(3'd3, 1'b0, 4, 10, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 3 || na !== 1 || ap !== 5 || nd !== 0 || ce !== 3'd3) begin
      fails++;
      $display("FAIL abort_last got sh=%0d ab=%0d@%0d dn=%0d cnt=%0d exp 3 1@5 0 3",
               ns, na, ap, nd, ce);
    end
    run_op(3'd5, 1'b0, 1, 8, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (ns !== 0 || na !== 1 || ap !== 2 || nd !== 0 || ce !== 3'd0) begin
      fails++;
      $display("FAIL abort_load got sh=%0d ab=%0d@%0d dn=%0d cnt=%0d exp 0 1@2 0 0",
               ns, na, ap, nd, ce);
    end
    run_op(3'd2, 1'b0, 4, 8, nl, ns, nd, na, la, sf, sl, da, ap, ra, ce);
    tests++;
    if (na !== 0 || nd !== 1 || da !== 4 || ce !== 3'd2) begin
      fails++;
      $display("FAIL abort_done got ab=%0d dn=%0d@%0d cnt=%0d exp 0 1@4 2",
               na, nd, da, ce);
    end
    abort = 1'b1;
    na = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (aborted || busy || !req_ready) na++;
    end
    abort = 1'b0;
    tests++;
    if (na !== 0) begin
      fails++;
      $display("FAIL abort_idle got bad_cycles=%0d exp=0", na);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    req_valid = 1'b1; req_len = 3'd5; req_dir = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done || aborted) pulses++;
    end
    tests++;
    if (!sr_shift_en || bit_cnt !== 3'd2) begin
      fails++;
      $display("FAIL rst_pre got shift=%b cnt=%0d exp 1 2", sr_shift_en, bit_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (outs() !== RST_OUT) begin
      fails++;
      $display("FAIL rst_mid got=%b exp=%b", outs(), RST_OUT);
    end
    @(negedge clk);
    tests++;
    if (outs() !== RST_OUT) begin
      fails++;
      $display("FAIL rst_hold got=%b exp=%b", outs(), RST_OUT);
    end
    reset = 1'b1; req_dir = 1'b0; req_len = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (!sr_load || sr_dir !== 1'b0 || bit_cnt !== 3'd0) begin
      fails++;
      $display("FAIL rst_accept got load=%b dir=%b cnt=%0d exp 1 0 0",
               sr_load, sr_dir, bit_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (aborted) pulses++;
    end
    tests++;
    if (pulses !== 0 || !req_ready) begin
      fails++;
      $display("FAIL rst_pulses got bad=%0d ready=%b exp 0 1", pulses, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    req_valid = 1'b1; req_len = 3'd2; req_dir = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_dir = 1'b0;
        req_len = 3'd1;
      end
      if (done && done_at < 0) done_at = c;
      if (c == 2) begin
        tests++;
        if (sr_dir !== 1'b1 || !sr_shift_en) begin
          fails++;
          $display("FAIL b2b_shift got dir=%b en=%b exp 1 1", sr_dir, sr_shift_en);
        end
      end
      if (c == 5) begin
        tests++;
        if (!req_ready || sr_dir !== 1'b1 || sr_load) begin
          fails++;
          $display("FAIL b2b_idle got rdy=%b dir=%b ld=%b exp 1 1 0",
                   req_ready, sr_dir, sr_load);
        end
      end
      if (c == 6) begin
        req_valid = 1'b0;
        tests++;
        if (!sr_load || sr_dir !== 1'b0 || req_ready) begin
          fails++;
          $display("FAIL b2b_accept got ld=%b dir=%b rdy=%b exp 1 0 0",
                   sr_load, sr_dir, req_ready);
        end
      end
      if (c == 8) begin
        tests++;
        if (!done || bit_cnt !== 3'd1) begin
          fails++;
          $display("FAIL b2b_done2 got done=%b cnt=%0d exp 1 1", done, bit_cnt);
        end
      end
    end
    tests++;
    if (done_at !== 4) begin
      fails++;
      $display("FAIL b2b_done1 got=%0d exp=4", done_at);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_len6();
    test_len_clamp();
    test_abort();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
